// File: rtl/fnd_pkg.sv
// Shared constants, FSM state type and double-dabble helper for the FND scan driver.
package fnd_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int VALUE_W    = 14;
    localparam int BCD_W      = 4;
    localparam int DD_ITER    = 14;

    localparam logic [VALUE_W-1:0] MAX_VALUE = 14'd9999;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Double-dabble correction: a nibble of 5 or more would overflow past 9 once doubled.
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/fnd_scan_driver_bin2bcd_seq.sv
// Sequential double-dabble: one shift-and-correct iteration per cycle after start.
module bin2bcd_seq
    import fnd_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [VALUE_W-1:0]            value,
    output logic [NUM_DIGITS*BCD_W-1:0]   bcd,
    output logic                          done
);

    logic [VALUE_W-1:0]          work;
    logic [3:0]                  iter;
    logic                        active;
    logic [NUM_DIGITS*BCD_W-1:0] adj;

    always_comb begin
        adj = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            adj[k*BCD_W +: BCD_W] = dd_adjust(bcd[k*BCD_W +: BCD_W]);
        end
    end

    // done marks the cycle in which the final iteration is being applied.
    assign done = active && (iter == 4'(DD_ITER - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            work   <= '0;
            bcd    <= '0;
            iter   <= '0;
            active <= 1'b0;
        end else if (start) begin
            work   <= value;
            bcd    <= '0;
            iter   <= '0;
            active <= 1'b1;
        end else if (active) begin
            bcd  <= {adj[NUM_DIGITS*BCD_W-2:0], work[VALUE_W-1]};
            work <= {work[VALUE_W-2:0], 1'b0};
            if (iter == 4'(DD_ITER - 1)) begin
                active <= 1'b0;
            end else begin
                iter <= iter + 4'd1;
            end
        end
    end

endmodule

// File: rtl/fnd_scan_driver.sv
// Accepts a binary value, converts it to BCD and time-multiplexes the four digits
// for the downstream BCD-to-FND decoder, optionally blanking leading zeros.
//
// state  | meaning
// IDLE   | ready for a new value; display holds the last committed digits
// CONV   | double-dabble running, one iteration per cycle
// COMMIT | finished BCD copied into the display registers in one step
module fnd_scan_driver
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [VALUE_W-1:0] i_value,
    input  logic               i_valid,
    output logic               o_ready,
    output logic               o_busy,
    output logic               o_ovf,
    output logic [1:0]         o_digitSelect,
    output logic [BCD_W-1:0]   o_bcd,
    output logic               o_en
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    state_t                      state;
    logic                        ready;
    logic                        busy;
    logic                        ovf;
    logic [NUM_DIGITS*BCD_W-1:0] display;
    logic [DIV_W-1:0]            div;
    logic [1:0]                  idx;

    logic                        accept;
    logic                        in_range;
    logic [VALUE_W-1:0]          value_sat;
    logic [NUM_DIGITS*BCD_W-1:0] conv_bcd;
    logic                        conv_done;
    logic [NUM_DIGITS-1:0]       upper_nz;

    assign accept    = i_valid && ready;
    assign in_range  = (i_value <= MAX_VALUE);
    assign value_sat = in_range ? i_value : MAX_VALUE;

    bin2bcd_seq u_bin2bcd (
        .clk   (i_clk),
        .reset (i_reset),
        .start (accept),
        .value (value_sat),
        .bcd   (conv_bcd),
        .done  (conv_done)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= IDLE;
            ready   <= 1'b1;
            busy    <= 1'b0;
            ovf     <= 1'b0;
            display <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        state <= CONV;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                        ovf   <= !in_range;
                    end
                end
                CONV: begin
                    if (conv_done) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    display <= conv_bcd;
                    state   <= IDLE;
                    ready   <= 1'b1;
                    busy    <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Scan timing runs freely so digit brightness is unaffected by conversions.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            div <= '0;
            idx <= '0;
        end else if (div == DIV_W'(SCAN_DIV - 1)) begin
            div <= '0;
            idx <= idx + 2'd1;
        end else begin
            div <= div + 1'b1;
        end
    end

    // upper_nz[k] is set when any digit from k up to the thousands place is non-zero.
    always_comb begin
        upper_nz    = '0;
        upper_nz[3] = |display[3*BCD_W +: BCD_W];
        upper_nz[2] = |display[2*BCD_W +: BCD_W] || upper_nz[3];
        upper_nz[1] = |display[1*BCD_W +: BCD_W] || upper_nz[2];
        upper_nz[0] = 1'b1;
    end

    assign o_ready       = ready;
    assign o_busy        = busy;
    assign o_ovf         = ovf;
    assign o_digitSelect = idx;
    assign o_bcd         = display[idx*BCD_W +: BCD_W];
    assign o_en          = !BLANK_LZ || upper_nz[idx];

endmodule

// File: doc/fnd_scan_driver.md
Name: fnd_scan_driver

Overview:
- Upstream stage of the BCD-to-FND decoder on the 4-digit 7-segment display.
- Accepts a binary value (0..9999) over a valid/ready handshake.
- Converts the value to four BCD digits with a sequential double-dabble.
- Time-multiplexes the digits, producing the digit index, BCD nibble and enable that the decoder consumes. Optionally blanks leading zeros.

Parameters:
SCAN_DIV  100000  clock cycles each digit is shown (min 2)
BLANK_LZ  1       1 = blank leading zeros; 0 = show all four digits
VALUE_W   14      width of i_value (fixed; 2^14 > 9999)

Ports:
i_clk          in   1        system clock, rising edge
i_reset        in   1        synchronous, active-high reset
i_value        in   14       binary value to display
i_valid        in   1        i_value presented this cycle
o_ready        out  1        block can accept a value (state IDLE)
o_busy         out  1        conversion in progress
o_ovf          out  1        last accepted value exceeded 9999 (saturated)
o_digitSelect  out  2        digit index: 0=ones, 1=tens, 2=hundreds, 3=thousands
o_bcd          out  4        BCD digit for o_digitSelect, 0..9
o_en           out  1        1 = drive digit, 0 = blank

Behaviour:
- Clocking and reset: one clock, i_clk. i_reset is synchronous and active-high; all state updates on the rising edge of i_clk.
- Reset values:
  - state IDLE
  - divider 0, digit index 0
  - display digits all 0
  - o_ready 1, o_busy 0, o_ovf 0
  - o_digitSelect 0, o_bcd 0, o_en 1, so the display shows "0"
- Reset during CONV aborts the conversion and clears the display.
- Handshake:
  - A value is accepted in cycle T when i_valid && o_ready.
  - i_valid while not ready is ignored. No queueing, no error flag.
- Saturation: at accept, i_value > 9999 is replaced by 9999 and o_ovf is set. o_ovf is cleared by the next in-range accept.
- FSM:
  - IDLE -> CONV on accept. The working register is loaded with the (saturated) value, the BCD shift register is zeroed, and the iteration count is 0.
  - CONV: one double-dabble iteration per cycle. Add 3 to each BCD nibble >= 5, then shift left 1 with the MSB of the binary value entering. Runs exactly 14 iterations, in cycles T+1..T+14.
  - CONV -> COMMIT after the 14th iteration.
  - COMMIT (cycle T+15): the four BCD nibbles are copied atomically into the display registers. Then -> IDLE.
  - New digits are visible on o_bcd from T+16. o_ready is 0 from T+1 through T+15.
  - o_busy = (state != IDLE).
- Scan:
  - The divider counts 0..SCAN_DIV-1 continuously, independent of the FSM.
  - At terminal count, the divider returns to 0 and the digit index increments modulo 4 (3 -> 0).
  - Each digit is therefore held for exactly SCAN_DIV cycles.
- Outputs o_digitSelect, o_bcd and o_en are combinational from registered state only: o_digitSelect = index, and o_bcd = display[index].
- Blanking:
  - With BLANK_LZ=1, o_en = 0 for index k >= 1 when display digits k..3 are all zero.
  - Digit 0 is never blanked.
  - With BLANK_LZ=0, o_en is always 1.
- Simultaneous COMMIT and scan tick: both take effect. The new index shows new data from the next cycle.
- The display never shows a partial conversion; the old value is held until COMMIT.

Decomposition:
- Shared package fnd_pkg:
  - NUM_DIGITS=4, MAX_VALUE=14'd9999, VALUE_W=14, BCD_W=4
  - state enum {IDLE, CONV, COMMIT}
  - DD_ITER=14
- One sub-module, bin2bcd_seq. It holds the double-dabble datapath (working register, 16-bit BCD shift register, iteration counter) with start/done. The top holds the FSM, handshake, divider, display registers and blanking.

Test Plan (SCAN_DIV=4):
- Reset mid-CONV (accept 1234, assert i_reset at T+5) -> next cycle: o_busy=0, o_ready=1, o_ovf=0, index 0, o_bcd=0, o_en=1. After that, 1234 never appears.
- Accept 1234 at T -> o_ready=0 during T+1..T+15. From T+16, a full scan shows idx0=4, idx1=3, idx2=2, idx3=1, all with o_en=1. Each digit is held 4 cycles and the index wraps 3->0.
- Accept 7 with BLANK_LZ=1 -> idx0: bcd 7, en 1; idx1..3: en 0. Same value with BLANK_LZ=0 -> all en 1, digits 0,0,0,7.
- Accept 12000 -> o_ovf=1 and the display shows 9999. Then accept 305 -> o_ovf=0, digits 5,0,3 with idx3 blanked.
- Accept 42, then assert i_valid with 99 at T+3 and T+10 -> both ignored and the display shows 42. A 99 at T+16 is accepted and shown from T+32.
- Accept 1000 -> digits 0,0,0,1 with all o_en=1 (inner zeros are not blanked). Then accept 0 -> only idx0 enabled, showing 0.
